// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver into a first-word-fall-through byte FIFO (8E1 when UART_RX_PARITY_EN is defined).
// Latency: byte on data_o 1 clk after the stop-bit sample (~9.5 bit periods + 2 clk sync after start edge).
// Backpressure: none on the line; a byte completing into a full FIFO is dropped and flagged on overrun_o.
module uart_rx #(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       rd_en_i,
  output logic [7:0] data_o,
  output logic       fifo_full_o,
  output logic       fifo_empty_o,
  output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       overrun_o
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam int HALF     = OVERSAMPLE / 2;
  localparam int AW       = $clog2(FIFO_DEPTH);

  if (TICK_DIV < 1) begin : g_chk_div
    $error("uart_rx: CLK_FREQ/(BAUD*OVERSAMPLE) must be >= 1");
  end
  if (OVERSAMPLE < 8) begin : g_chk_os
    $error("uart_rx: OVERSAMPLE must be >= 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state;
  logic              rx_meta, rx_s;
  logic [DIV_W-1:0]  div_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              brk;
  logic              tick, bit_end, stop_sample, pop_ok, room, push, par_ok;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;

  assign tick        = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign bit_end     = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign stop_sample = (state == STOP) && bit_end;

  assign fifo_empty_o = (wr_ptr == rd_ptr);
  assign fifo_full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign data_o       = mem[rd_ptr[AW-1:0]];
  assign pop_ok       = rd_en_i && !fifo_empty_o;
  // A full FIFO still accepts the byte when the same cycle frees a slot.
  assign room         = !fifo_full_o || pop_ok;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_ok = ~(^shift ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  assign push = stop_sample && rx_s && par_ok && room;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      div_cnt     <= '0;
      os_cnt      <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      brk         <= 1'b1;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx_i;
      rx_s        <= rx_meta;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) os_cnt <= os_cnt + 1'b1;

      case (state)
        IDLE: begin
          // After a break or reset the line must be seen high before re-arming.
          if (rx_s) brk <= 1'b0;
          if (!brk && !rx_s) begin
            state   <= START;
            div_cnt <= '0;
            os_cnt  <= '0;
          end
        end
        START: begin
          if (tick && (os_cnt == OS_W'(HALF - 1))) begin
            os_cnt  <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            os_cnt         <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            os_cnt  <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            os_cnt <= '0;
            state  <= IDLE;
            if (!rx_s) begin
              frame_err_o <= 1'b1;
              brk         <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (!par_ok) parity_err_o <= 1'b1;
`endif
            else if (!room) overrun_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed vector table, hand-written corner sequences and random frames vs a queue model.
module tb_uart_rx;
  localparam int CLK_FREQ   = 9_000_000;
  localparam int BAUD       = 115_200;
  localparam int OVERSAMPLE = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int BIT        = TICK_DIV * OVERSAMPLE;
  localparam int NV         = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic [7:0] data_o;
  logic       fifo_full_o, fifo_empty_o, frame_err_o, overrun_o;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i), .rd_en_i(rd_en_i), .data_o(data_o),
    .fifo_full_o(fifo_full_o), .fifo_empty_o(fifo_empty_o),
    .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic       exp_empty;
    logic [7:0] exp_dout;
    int         exp_fe;
  } vec_t;
  vec_t vecs[NV];

  int         n_pass = 0;
  int         n_total = 0;
  int         fe_seen = 0;
  int         ovr_seen = 0;
  int         exp_fe = 0;
  int         exp_ovr = 0;
  int         fe0, ovr0;
  logic [7:0] got, want;
  logic [7:0] model_q[$];

  always @(negedge clk) begin
    if (frame_err_o) fe_seen++;
    if (overrun_o) ovr_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial frame at the nominal bit period; the model applies the receive rules to the queue.
  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int hold_low);
    rx_i = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      cyc(BIT);
    end
    rx_i = stop_val;
    cyc(BIT);
    if (!stop_val && hold_low > 0) cyc(hold_low);
    rx_i = 1'b1;
    if (!stop_val) exp_fe++;
    else if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
    else exp_ovr++;
  endtask

  task automatic read_byte(output logic [7:0] b);
    logic [7:0] drop;
    b = data_o;
    rd_en_i = 1'b1;
    cyc(1);
    rd_en_i = 1'b0;
    if (model_q.size() > 0) drop = model_q.pop_front();
  endtask

  task automatic check_model(input string tag);
    check({tag, " empty"}, fifo_empty_o, model_q.size() == 0);
    check({tag, " full"}, fifo_full_o, model_q.size() == FIFO_DEPTH);
    check({tag, " frame_err count"}, fe_seen, exp_fe);
    check({tag, " overrun count"}, ovr_seen, exp_ovr);
    if (model_q.size() > 0) check({tag, " head"}, data_o, model_q[0]);
  endtask

  initial begin
    vecs[0] = '{din: 8'h45, stop: 1'b1, exp_empty: 1'b0, exp_dout: 8'h45, exp_fe: 0};
    vecs[1] = '{din: 8'hC3, stop: 1'b1, exp_empty: 1'b0, exp_dout: 8'hC3, exp_fe: 0};
    vecs[2] = '{din: 8'h3C, stop: 1'b0, exp_empty: 1'b1, exp_dout: 8'h00, exp_fe: 1};
    vecs[3] = '{din: 8'h80, stop: 1'b1, exp_empty: 1'b0, exp_dout: 8'h80, exp_fe: 0};
    vecs[4] = '{din: 8'h01, stop: 1'b1, exp_empty: 1'b0, exp_dout: 8'h01, exp_fe: 0};
    vecs[5] = '{din: 8'hFF, stop: 1'b0, exp_empty: 1'b1, exp_dout: 8'h00, exp_fe: 1};

    // Reset values
    rst = 1'b1;
    cyc(4);
    check("reset empty", fifo_empty_o, 1'b1);
    check("reset full", fifo_full_o, 1'b0);
    check("reset frame_err", frame_err_o, 1'b0);
    check("reset overrun", overrun_o, 1'b0);
    check("reset data", data_o, 8'h00);
    rst = 1'b0;
    cyc(2 * BIT);
    check("idle empty", fifo_empty_o, 1'b1);

    // Single frames from the vector table
    for (int i = 0; i < NV; i++) begin
      fe0 = fe_seen;
      send_frame(vecs[i].din, vecs[i].stop, 0);
      cyc(BIT);
      check($sformatf("vec%0d empty", i), fifo_empty_o, vecs[i].exp_empty);
      check($sformatf("vec%0d frame_err", i), fe_seen - fe0, vecs[i].exp_fe);
      if (!vecs[i].exp_empty) begin
        read_byte(got);
        check($sformatf("vec%0d data", i), got, vecs[i].exp_dout);
        check($sformatf("vec%0d empty after read", i), fifo_empty_o, 1'b1);
      end
    end

    // Back-to-back frames with minimum stop
    fe0 = fe_seen; ovr0 = ovr_seen;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    send_frame(8'hA5, 1'b1, 0);
    cyc(4);
    check("b2b model", model_q.size(), 3);
    check("b2b not empty", fifo_empty_o, 1'b0);
    read_byte(got); check("b2b read0", got, 8'h00);
    read_byte(got); check("b2b read1", got, 8'hFF);
    read_byte(got); check("b2b read2", got, 8'hA5);
    check("b2b empty", fifo_empty_o, 1'b1);
    check("b2b no err", (fe_seen - fe0) + (ovr_seen - ovr0), 0);

    // Overrun: FIFO_DEPTH+1 frames without reading
    ovr0 = ovr_seen;
    for (int i = 1; i <= FIFO_DEPTH + 1; i++) begin
      send_frame(8'(i), 1'b1, 0);
      if (i == FIFO_DEPTH - 1) check("ovr not yet full", fifo_full_o, 1'b0);
      if (i == FIFO_DEPTH) check("ovr full", fifo_full_o, 1'b1);
    end
    cyc(4);
    check("ovr pulse count", ovr_seen - ovr0, 1);
    check("ovr still full", fifo_full_o, 1'b1);
    for (int i = 1; i <= FIFO_DEPTH; i++) begin
      read_byte(got);
      check($sformatf("ovr read%0d", i), got, 8'(i));
    end
    check("ovr drained", fifo_empty_o, 1'b1);

    // Frame error followed by a held-low break, then a good frame
    fe0 = fe_seen;
    send_frame(8'h3C, 1'b0, 2 * BIT);
    cyc(2 * BIT);
    check("brk no push", fifo_empty_o, 1'b1);
    send_frame(8'h5A, 1'b1, 0);
    cyc(4);
    check("brk frame_err once", fe_seen - fe0, 1);
    read_byte(got);
    check("brk data", got, 8'h5A);
    check("brk only one", fifo_empty_o, 1'b1);

    // Quarter-bit glitch on idle line
    fe0 = fe_seen; ovr0 = ovr_seen;
    rx_i = 1'b0;
    cyc(BIT / 4);
    rx_i = 1'b1;
    cyc(2 * BIT);
    check("glitch no push", fifo_empty_o, 1'b1);
    check("glitch no err", (fe_seen - fe0) + (ovr_seen - ovr0), 0);
    send_frame(8'h96, 1'b1, 0);
    cyc(4);
    read_byte(got);
    check("glitch rearm data", got, 8'h96);

    // Reset during bit 4 of a 0x81 frame with two bytes queued
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    check("rst pre count", model_q.size(), 2);
    check("rst pre empty", fifo_empty_o, 1'b0);
    want = 8'h81;
    rx_i = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_i = want[i];
      cyc(BIT);
    end
    rx_i = want[4];
    cyc(BIT / 2);
    rst = 1'b1;
    cyc(1);
    check("rst flush empty", fifo_empty_o, 1'b1);
    check("rst flush data", data_o, 8'h00);
    model_q.delete();
    rx_i = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(2 * BIT);
    send_frame(8'h81, 1'b1, 0);
    cyc(4);
    check("rst after data", data_o, 8'h81);
    read_byte(got);
    check("rst after empty", fifo_empty_o, 1'b1);

    // Random frames against the queue model
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic       stop_ok;
      int         nrd;
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 9) != 0);
      send_frame(b, stop_ok, $urandom_range(0, BIT));
      cyc($urandom_range(2, BIT));
      check_model($sformatf("rnd%0d", i));
      nrd = $urandom_range(0, 2);
      for (int r = 0; r < nrd; r++) begin
        if (model_q.size() > 0) begin
          want = model_q[0];
          read_byte(got);
          check($sformatf("rnd%0d read%0d", i, r), got, want);
        end
      end
    end
    while (model_q.size() > 0) begin
      want = model_q[0];
      read_byte(got);
      check("rnd drain", got, want);
    end
    check_model("final");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver with output FIFO; counterpart of the team's UartTx block. Samples an asynchronous 8N1 serial line, reconstructs bytes, and pushes them into an internal FIFO. Downstream logic reads them with a rd_en/data handshake. Sits at the board boundary, e.g. fed from a ck_io pin in receiver top-levels.

Parameters:
CLK_FREQ, 125_000_000, system clock frequency in Hz
BAUD, 115_200, serial bit rate
OVERSAMPLE, 16, sample ticks per bit period; integer ≥ 8
FIFO_DEPTH, 16, byte FIFO depth; power of two ≥ 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_i  input  1  asynchronous serial input; idle high
rd_en_i  input  1  pop request; ignored when FIFO empty
data_o  output  8  FIFO head byte; valid when fifo_empty_o=0
fifo_full_o  output  1  FIFO holds FIFO_DEPTH bytes
fifo_empty_o  output  1  FIFO holds 0 bytes
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
overrun_o  output  1  one-cycle pulse: byte completed while FIFO full; byte dropped

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: fifo_empty_o=1, fifo_full_o=0, frame_err_o=0, overrun_o=0, data_o=8'h00. FSM=IDLE. Synchronizer flops=1. All counters=0.
- Synchronizer: rx_i passes through 2 flops to give rx_s. Metastability latency is 2 clk.
- Tick generator: free-running counter. It pulses `tick` every TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clk, using integer division. TICK_DIV must be ≥ 1 (elaboration $error otherwise). The counter restarts at 0 on entry to START so that sampling is phase-aligned.
- FSM states:
  - IDLE: wait for rx_s=0, then go to START with tick count cleared.
  - START: at OVERSAMPLE/2 ticks, sample rx_s. If 1, the start was false (glitch): go to IDLE. If 0, go to DATA with bit index=0 and tick count cleared.
  - DATA: every OVERSAMPLE ticks, sample rx_s into shift[bit index]. Data is LSB first. After index 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - If 1 and FIFO not full: push the byte.
    - If 1 and FIFO full: pulse overrun_o and drop the byte.
    - If 0: pulse frame_err_o and drop the byte.
    - In all cases go to IDLE. If rx_s=0 after a frame error, IDLE waits for the line to return high before re-arming. This is tracked as a break flag, cleared when rx_s=1.
- FIFO: circular buffer with pointers of width $clog2(FIFO_DEPTH)+1.
  - data_o shows mem[rd_ptr] combinationally; this is first-word fall-through.
  - A pop on rd_en_i && !empty advances rd_ptr. The next byte appears on data_o in the following cycle.
  - A push and a pop in the same cycle both take effect, and the count is unchanged. A push is allowed when full only if a pop occurs in the same cycle. In that case there is no overrun.
  - Pointers wrap modulo 2*FIFO_DEPTH. Full when the MSBs differ and the rest of the bits are equal.
- Latency: a byte is visible on data_o 1 clk after the STOP sample, i.e. about 9.5 bit periods after the start-bit falling edge plus 2 clk of synchronizer delay.
- Reset mid-frame: the partial byte is discarded, the FIFO is flushed, and the FSM returns to IDLE. If rx_i is low when rst deasserts, that is treated as a start edge. The break flag is set on reset, so the line must be seen high first.

Optional Feature:
UART_RX_PARITY_EN: when defined, the frame is 8E1. A PARITY state between DATA and STOP samples an even-parity bit.
- On mismatch, parity_err_o (an extra output port, 1-cycle pulse) fires at the STOP sample and the byte is dropped.
- When the macro is undefined, there is no PARITY state and no parity_err_o port; the frame is 8N1.

Test Plan:
1. Reset, then drive 0x45 at 115200 baud (TICK_DIV=67) -> fifo_empty_o falls and data_o=8'h45; pulse rd_en_i -> fifo_empty_o=1.
2. Send 0x00, 0xFF, 0xA5 back-to-back with minimum stop, no reads -> FIFO holds 3 entries. Three reads return 00, FF, A5 in order, with no err pulses.
3. Send FIFO_DEPTH+1 bytes (0x01..0x11) without reading -> fifo_full_o=1 after byte 16. One overrun_o pulse at byte 17's STOP. Reads return 0x01..0x10.
4. Send 0x3C with stop bit forced low, then hold the line low for 2 bit periods, then idle, then send 0x5A -> frame_err_o pulses once, 0x3C is dropped, there is no spurious frame during the low period, and the FIFO contains only 0x5A.
5. Drive a 0.25-bit low glitch on idle rx_i -> no push and no err pulses, and the FSM is back in IDLE.
6. Assert rst during bit 4 of a 0x81 frame, with FIFO holding 2 bytes -> fifo_empty_o=1 next cycle. After release and a full 0x81 frame, data_o=8'h81.
